// File: rtl/timer_logic.sv
// rtl/timer_logic.sv - down-counting timer core; TIMER_AUTO_RELOAD_EN selects periodic mode
// Priority per edge: stop > start > decrement; all outputs are registered.
module timer_logic #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             expired_q, expired_d;
  logic             busy_q, busy_d;
`ifdef TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    expired_d = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
    reload_d  = reload_q;
`endif
    if (stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (start) begin
      count_d = load_value;
      state_d = RUN;
`ifdef TIMER_AUTO_RELOAD_EN
      reload_d = load_value;
`endif
    end else if (state_q == RUN) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        // Terminal count: covers both the normal 1->0 step and a zero load.
        expired_d = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
        count_d   = reload_q;
`else
        count_d   = '0;
        state_d   = IDLE;
`endif
      end
    end
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      expired_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
      reload_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      expired_q <= expired_d;
      busy_q    <= busy_d;
`ifdef TIMER_AUTO_RELOAD_EN
      reload_q  <= reload_d;
`endif
    end
  end

  assign expired = expired_q;
  assign busy    = busy_q;
  assign count   = count_q;

endmodule

// File: tb/tb_timer_logic.sv
// tb/tb_timer_logic.sv - self-checking bench for timer_logic against an elapsed-time reference model
module tb_timer_logic;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         stop;
  logic [W-1:0] load_value;
  logic         expired;
  logic         busy;
  logic [W-1:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  bit           m_run;
  longint       m_k;
  longint       m_n;
  logic [W-1:0] m_count;
  bit           m_exp;

  timer_logic #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .load_value(load_value), .expired(expired), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_run = 0; m_k = 0; m_n = 0; m_count = '0; m_exp = 0;
  endtask

  task automatic model_eval();
`ifdef TIMER_AUTO_RELOAD_EN
    if (m_n == 0) begin
      m_count = '0; m_exp = 1;
    end else if (m_k % m_n == 0) begin
      m_count = W'(m_n); m_exp = 1;
    end else begin
      m_count = W'(m_n - (m_k % m_n));
    end
`else
    longint period;
    period = (m_n == 0) ? 1 : m_n;
    if (m_k >= period) begin
      m_count = '0; m_exp = 1; m_run = 0;
    end else begin
      m_count = W'(m_n - m_k);
    end
`endif
  endtask

  task automatic step(input bit s, input bit p, input logic [W-1:0] v);
    start = s; stop = p; load_value = v;
    @(posedge clk); #1;
    m_exp = 0;
    if (p) begin
      m_run = 0;
    end else if (s) begin
      m_run = 1; m_k = 0; m_n = longint'(v); m_count = v;
    end else if (m_run) begin
      m_k++;
      model_eval();
    end
    start = 0; stop = 0; load_value = W'($urandom_range(0, 1000));
  endtask

  task automatic test_reset();
    reset = 1; start = 0; stop = 0; load_value = '0;
    #2;
    n_tests++;
    if ({count, busy, expired} !== {W'(0), 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_initial: count=%0d busy=%0b expired=%0b, expected 0 0 0", count, busy, expired);
    end
    @(posedge clk); #1; reset = 0; model_clear();
    step(1, 0, W'(12));
    for (int i = 0; i < 5; i++) step(0, 0, '0);
    #3 reset = 1;
    #1;
    n_tests++;
    if ({count, busy, expired} !== {W'(0), 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async_midcount: count=%0d busy=%0b expired=%0b, expected 0 0 0", count, busy, expired);
    end
    @(posedge clk); #1; reset = 0; model_clear();
    for (int i = 0; i < 15; i++) begin
      step(0, 0, '0);
      n_tests++;
      if ({count, busy, expired} !== {W'(0), 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_quiet[%0d]: count=%0d busy=%0b expired=%0b, expected 0 0 0", i, count, busy, expired);
      end
    end
  endtask

  task automatic test_one_shot();
    int pulses = 0;
    int at = -1;
    step(1, 0, W'(12));
    n_tests++;
    if (count !== W'(12) || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL one_shot_load: count=%0d busy=%0b, expected 12 1", count, busy);
    end
    for (int i = 1; i <= 15; i++) begin
      step(0, 0, '0);
      if (expired) begin pulses++; at = i; end
      n_tests++;
      if ({count, busy, expired} !== {m_count, m_run, m_exp}) begin
        n_fail++;
        $display("FAIL one_shot[%0d]: count=%0d busy=%0b expired=%0b, expected %0d %0b %0b",
                 i, count, busy, expired, m_count, m_run, m_exp);
      end
    end
    n_tests++;
    if (pulses !== 1 || at !== 12) begin
      n_fail++;
      $display("FAIL one_shot_timing: pulses=%0d at_edge=%0d, expected 1 at 12", pulses, at);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 0, W'(3));
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, '0);
      n_tests++;
      if (expired !== (i == 3) || {count, busy} !== {m_count, m_run}) begin
        n_fail++;
        $display("FAIL b2b_three[%0d]: count=%0d busy=%0b expired=%0b, expected %0d %0b %0b",
                 i, count, busy, expired, m_count, m_run, (i == 3));
      end
    end
    step(1, 0, W'(0));
    step(0, 0, '0);
    n_tests++;
    if (expired !== 1'b1 || count !== W'(0)) begin
      n_fail++;
      $display("FAIL b2b_zero: expired=%0b count=%0d, expected 1 0", expired, count);
    end
  endtask

  task automatic test_stop_hold();
    step(1, 0, W'(5));
    for (int i = 0; i < 3; i++) step(0, 0, '0);
    step(0, 1, '0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, '0);
      n_tests++;
      if ({count, busy, expired} !== {W'(2), 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL stop_hold[%0d]: count=%0d busy=%0b expired=%0b, expected 2 0 0", i, count, busy, expired);
      end
    end
    step(1, 0, W'(4));
    n_tests++;
    if (count !== W'(4) || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_reload: count=%0d busy=%0b, expected 4 1", count, busy);
    end
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, '0);
      n_tests++;
      if (expired !== (i == 4) || {count, busy} !== {m_count, m_run}) begin
        n_fail++;
        $display("FAIL stop_after_reload[%0d]: count=%0d busy=%0b expired=%0b, expected %0d %0b %0b",
                 i, count, busy, expired, m_count, m_run, (i == 4));
      end
    end
  endtask

  task automatic test_simultaneous_restart();
    step(1, 0, W'(20));
    step(0, 0, '0);
    step(0, 0, '0);
    step(1, 1, W'(99));
    n_tests++;
    if ({count, busy, expired} !== {W'(18), 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL start_stop_together: count=%0d busy=%0b expired=%0b, expected 18 0 0", count, busy, expired);
    end
    step(1, 0, W'(10));
    for (int i = 0; i < 3; i++) step(0, 0, '0);
    n_tests++;
    if (count !== W'(7)) begin
      n_fail++;
      $display("FAIL restart_pre: count=%0d, expected 7", count);
    end
    step(1, 0, W'(10));
    n_tests++;
    if (count !== W'(10) || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_load: count=%0d busy=%0b, expected 10 1", count, busy);
    end
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, '0);
      n_tests++;
      if (expired !== (i == 10) || {count, busy} !== {m_count, m_run}) begin
        n_fail++;
        $display("FAIL restart[%0d]: count=%0d busy=%0b expired=%0b, expected %0d %0b %0b",
                 i, count, busy, expired, m_count, m_run, (i == 10));
      end
    end
  endtask

  task automatic test_random();
    bit prev_exp = 0;
    for (int i = 0; i < 400; i++) begin
      bit s, p;
      s = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 15) == 0);
      step(s, p, W'($urandom_range(0, 20)));
      n_tests++;
      if ({count, busy, expired} !== {m_count, m_run, m_exp}) begin
        n_fail++;
        $display("FAIL random[%0d]: count=%0d busy=%0b expired=%0b, expected %0d %0b %0b",
                 i, count, busy, expired, m_count, m_run, m_exp);
      end
`ifndef TIMER_AUTO_RELOAD_EN
      n_tests++;
      if (prev_exp && expired) begin
        n_fail++;
        $display("FAIL random_double_pulse[%0d]: expired=%0b, expected 0", i, expired);
      end
`endif
      prev_exp = expired;
    end
  endtask

`ifdef TIMER_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    logic [W-1:0] held;
    step(1, 0, W'(4));
    for (int i = 1; i <= 13; i++) begin
      step(0, 0, '0);
      n_tests++;
      if (expired !== (i % 4 == 0) || {count, busy} !== {m_count, m_run}) begin
        n_fail++;
        $display("FAIL auto_reload[%0d]: count=%0d busy=%0b expired=%0b, expected %0d %0b %0b",
                 i, count, busy, expired, m_count, m_run, (i % 4 == 0));
      end
    end
    step(0, 1, '0);
    held = m_count;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, '0);
      n_tests++;
      if ({count, busy, expired} !== {held, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL auto_stop[%0d]: count=%0d busy=%0b expired=%0b, expected %0d 0 0",
                 i, count, busy, expired, held);
      end
    end
  endtask
`endif

  initial begin
    model_clear();
    test_reset();
    test_one_shot();
    test_back_to_back();
    test_stop_hold();
    test_simultaneous_restart();
    test_random();
`ifdef TIMER_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
